// File: rtl/move_ctrl_pkg.sv
// move_ctrl_pkg: shared constants for the player move controller.
//   - Tile ids for the map RAM (ground, wall, key, door, slime families).
//   - Direction codes carried on move_dir.
//   - FSM state encoding, also exported on the debug port.
//   - Small helpers that classify a tile id into a tile family.
package move_ctrl_pkg;

  // Tile ids stored in map RAM.
  localparam logic [15:0] RS_ground_0 = 16'h0000;
  localparam logic [15:0] RS_wall_0   = 16'h0001;
  localparam logic [15:0] RS_wall_1   = 16'h0002;
  localparam logic [15:0] RS_key_0    = 16'h0010;
  localparam logic [15:0] RS_door_0   = 16'h0020;
  localparam logic [15:0] RS_slime_0  = 16'h0030;
  localparam logic [15:0] RS_slime_1  = 16'h0031;

  // Direction codes on move_dir.
  localparam logic [1:0] DIR_UP    = 2'd0;  // y-1
  localparam logic [1:0] DIR_DOWN  = 2'd1;  // y+1
  localparam logic [1:0] DIR_LEFT  = 2'd2;  // x-1
  localparam logic [1:0] DIR_RIGHT = 2'd3;  // x+1

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_EVAL   = 2'd2,
    S_COMMIT = 2'd3
  } move_state_e;

  function automatic logic is_wall(input logic [15:0] tile);
    return (tile == RS_wall_0) || (tile == RS_wall_1);
  endfunction

  function automatic logic is_key(input logic [15:0] tile);
    return tile == RS_key_0;
  endfunction

  function automatic logic is_door(input logic [15:0] tile);
    return tile == RS_door_0;
  endfunction

  function automatic logic is_slime(input logic [15:0] tile);
    return (tile == RS_slime_0) || (tile == RS_slime_1);
  endfunction

endpackage

// File: rtl/move_ctrl_rule_eval.sv
// tile_rule_eval: purely combinational interaction rules for one move.
// Inputs : tile      - tile id read from the target cell
//          tgt_x/y   - target cell
//          cur_x/y   - current player position
//          keys      - current key count
//          health    - current health
// Outputs: next_x/y, next_keys, next_health - player state after the move
//          next_tile - tile id to leave in the target cell
//          changed   - target tile was consumed (needs a map write)
//          blocked   - player stays where it is
module tile_rule_eval
  import move_ctrl_pkg::*;
#(
  parameter int MONSTER_DMG = 3
) (
  input  logic [15:0] tile,
  input  logic [3:0]  tgt_x,
  input  logic [3:0]  tgt_y,
  input  logic [3:0]  cur_x,
  input  logic [3:0]  cur_y,
  input  logic [3:0]  keys,
  input  logic [7:0]  health,
  output logic [3:0]  next_x,
  output logic [3:0]  next_y,
  output logic [3:0]  next_keys,
  output logic [7:0]  next_health,
  output logic [15:0] next_tile,
  output logic        changed,
  output logic        blocked
);

  localparam logic [7:0] DMG = 8'(MONSTER_DMG);

  always_comb begin
    next_x      = tgt_x;
    next_y      = tgt_y;
    next_keys   = keys;
    next_health = health;
    next_tile   = tile;
    changed     = 1'b0;
    blocked     = 1'b0;

    if (is_wall(tile)) begin
      blocked = 1'b1;
    end else if (is_key(tile)) begin
      // A full key ring still picks the key up; the count just saturates.
      if (keys != 4'hF) next_keys = keys + 4'd1;
      next_tile = RS_ground_0;
      changed   = 1'b1;
    end else if (is_door(tile)) begin
      if (keys == 4'd0) begin
        blocked = 1'b1;
      end else begin
        next_keys = keys - 4'd1;
        next_tile = RS_ground_0;
        changed   = 1'b1;
      end
    end else if (is_slime(tile)) begin
      // Compare first so the subtraction can never underflow.
      if (health > DMG) begin
        next_health = health - DMG;
        next_tile   = RS_ground_0;
        changed     = 1'b1;
      end else begin
        blocked = 1'b1;
      end
    end

    if (blocked) begin
      next_x = cur_x;
      next_y = cur_y;
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: executes one player move per request against the tile map.
// Handshake: a move is taken on a clock edge where move_valid && move_ready;
//   move_ready is high only in IDLE, and move_valid seen in any other state
//   is dropped (not queued).
// Ports: clk/rst_n (async active-low); move_valid/move_dir/move_ready request;
//   map_rd_en/map_rd_addr/map_rd_data registered-read port ({y,x} address,
//   data valid the cycle after the strobe); map_wr_en/map_wr_addr/map_wr_data
//   write-back of consumed tiles; player_x/player_y/key_num/health player
//   state; move_done/move_blocked one-cycle completion pulses; state_dbg FSM
//   state for observation.
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter int INIT_X      = 1,
  parameter int INIT_Y      = 1,
  parameter int INIT_HEALTH = 100,
  parameter int MONSTER_DMG = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic        map_rd_en,
  output logic [7:0]  map_rd_addr,
  input  logic [15:0] map_rd_data,
  output logic        map_wr_en,
  output logic [7:0]  map_wr_addr,
  output logic [15:0] map_wr_data,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  key_num,
  output logic [7:0]  health,
  output logic        move_done,
  output logic        move_blocked,
  output move_state_e state_dbg
);

  move_state_e state;
  logic [3:0]  tgt_x_q, tgt_y_q;

  // Target cell from the live position and direction; the edge check comes
  // before the add/sub so the 4-bit position never wraps.
  logic [3:0] tgt_x, tgt_y;
  logic       off_grid;

  always_comb begin
    tgt_x    = player_x;
    tgt_y    = player_y;
    off_grid = 1'b0;
    unique case (move_dir)
      DIR_UP:    if (player_y == 4'd0)  off_grid = 1'b1; else tgt_y = player_y - 4'd1;
      DIR_DOWN:  if (player_y == 4'd15) off_grid = 1'b1; else tgt_y = player_y + 4'd1;
      DIR_LEFT:  if (player_x == 4'd0)  off_grid = 1'b1; else tgt_x = player_x - 4'd1;
      default:   if (player_x == 4'd15) off_grid = 1'b1; else tgt_x = player_x + 4'd1;
    endcase
  end

  logic [3:0]  ev_x, ev_y, ev_keys;
  logic [7:0]  ev_health;
  logic [15:0] ev_tile;
  logic        ev_changed, ev_blocked;

  tile_rule_eval #(
    .MONSTER_DMG (MONSTER_DMG)
  ) u_rule (
    .tile        (map_rd_data),
    .tgt_x       (tgt_x_q),
    .tgt_y       (tgt_y_q),
    .cur_x       (player_x),
    .cur_y       (player_y),
    .keys        (key_num),
    .health      (health),
    .next_x      (ev_x),
    .next_y      (ev_y),
    .next_keys   (ev_keys),
    .next_health (ev_health),
    .next_tile   (ev_tile),
    .changed     (ev_changed),
    .blocked     (ev_blocked)
  );

  assign state_dbg = state;

  // The EVAL edge loads the rule result straight into the output registers,
  // so the new player state and write strobe are visible in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tgt_x_q      <= 4'd0;
      tgt_y_q      <= 4'd0;
      move_ready   <= 1'b1;
      map_rd_en    <= 1'b0;
      map_rd_addr  <= 8'd0;
      map_wr_en    <= 1'b0;
      map_wr_addr  <= 8'd0;
      map_wr_data  <= 16'd0;
      player_x     <= 4'(INIT_X);
      player_y     <= 4'(INIT_Y);
      key_num      <= 4'd0;
      health       <= 8'(INIT_HEALTH);
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
    end else begin
      map_rd_en    <= 1'b0;
      map_wr_en    <= 1'b0;
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (move_valid && move_ready) begin
            move_ready <= 1'b0;
            tgt_x_q    <= tgt_x;
            tgt_y_q    <= tgt_y;
            if (off_grid) begin
              // Nothing to read: finish immediately as a blocked move.
              state        <= S_COMMIT;
              move_done    <= 1'b1;
              move_blocked <= 1'b1;
            end else begin
              state       <= S_READ;
              map_rd_en   <= 1'b1;
              map_rd_addr <= {tgt_y, tgt_x};
            end
          end
        end
        S_READ: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          state        <= S_COMMIT;
          player_x     <= ev_x;
          player_y     <= ev_y;
          key_num      <= ev_keys;
          health       <= ev_health;
          move_done    <= 1'b1;
          move_blocked <= ev_blocked;
          if (ev_changed) begin
            map_wr_en   <= 1'b1;
            map_wr_addr <= {tgt_y_q, tgt_x_q};
            map_wr_data <= ev_tile;
          end
        end
        S_COMMIT: begin
          state      <= S_IDLE;
          move_ready <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: directed bench for move_ctrl with a registered-read map RAM.
module tb_move_ctrl;
  import move_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        map_rd_en;
  logic [7:0]  map_rd_addr;
  logic [15:0] map_rd_data;
  logic        map_wr_en;
  logic [7:0]  map_wr_addr;
  logic [15:0] map_wr_data;
  logic [3:0]  player_x, player_y, key_num;
  logic [7:0]  health;
  logic        move_done, move_blocked;
  move_state_e state_dbg;

  move_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .map_rd_en    (map_rd_en),
    .map_rd_addr  (map_rd_addr),
    .map_rd_data  (map_rd_data),
    .map_wr_en    (map_wr_en),
    .map_wr_addr  (map_wr_addr),
    .map_wr_data  (map_wr_data),
    .player_x     (player_x),
    .player_y     (player_y),
    .key_num      (key_num),
    .health       (health),
    .move_done    (move_done),
    .move_blocked (move_blocked),
    .state_dbg    (state_dbg)
  );

  // ---------------- map RAM model ----------------
  logic [15:0] mem [256];
  initial map_rd_data = 16'd0;
  always @(posedge clk) begin
    if (map_rd_en) map_rd_data <= mem[map_rd_addr];
    if (map_wr_en) mem[map_wr_addr] = map_wr_data;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full move with cycle-accurate checks.
  task automatic do_move(input string tag, input logic [1:0] dir, input bit in_grid,
                         input bit exp_blk, input bit exp_wr, input logic [7:0] addr,
                         input logic [3:0] ex, input logic [3:0] ey,
                         input logic [3:0] ek, input logic [7:0] eh);
    chk({tag, "_ready_pre"}, 16'(move_ready), 16'd1);
    move_valid = 1'b1;
    move_dir   = dir;
    cyc();
    move_valid = 1'b0;
    if (in_grid) begin
      chk({tag, "_rd_en"}, 16'(map_rd_en), 16'd1);
      chk({tag, "_rd_addr"}, 16'(map_rd_addr), 16'(addr));
      chk({tag, "_ready_busy"}, 16'(move_ready), 16'd0);
      chk({tag, "_done_early"}, 16'(move_done), 16'd0);
      cyc();
      chk({tag, "_rd_en_off"}, 16'(map_rd_en), 16'd0);
      chk({tag, "_done_early2"}, 16'(move_done), 16'd0);
      cyc();
    end else begin
      chk({tag, "_no_rd"}, 16'(map_rd_en), 16'd0);
    end
    chk({tag, "_done"}, 16'(move_done), 16'd1);
    chk({tag, "_blocked"}, 16'(move_blocked), 16'(exp_blk));
    chk({tag, "_wr_en"}, 16'(map_wr_en), 16'(exp_wr));
    if (exp_wr) begin
      chk({tag, "_wr_addr"}, 16'(map_wr_addr), 16'(addr));
      chk({tag, "_wr_data"}, map_wr_data, RS_ground_0);
    end
    chk({tag, "_x"}, 16'(player_x), 16'(ex));
    chk({tag, "_y"}, 16'(player_y), 16'(ey));
    chk({tag, "_keys"}, 16'(key_num), 16'(ek));
    chk({tag, "_health"}, 16'(health), 16'(eh));
    cyc();
    chk({tag, "_done_clr"}, 16'(move_done), 16'd0);
    chk({tag, "_blk_clr"}, 16'(move_blocked), 16'd0);
    chk({tag, "_wr_clr"}, 16'(map_wr_en), 16'd0);
    chk({tag, "_ready_back"}, 16'(move_ready), 16'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] px, py, pk;
  logic [7:0] ph;
  int done_cnt, ready_cnt, first_ready;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = RS_ground_0;
    mem[8'h13] = RS_key_0;
    mem[8'h14] = RS_door_0;
    mem[8'h15] = RS_door_0;
    mem[8'h24] = RS_wall_1;
    move_valid = 1'b0;
    move_dir   = DIR_UP;
    rst_n      = 1'b0;
    repeat (3) cyc();
    chk("rst_hold_x", 16'(player_x), 16'd1);
    chk("rst_hold_ready", 16'(move_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Reset values
    chk("rst_x", 16'(player_x), 16'd1);
    chk("rst_y", 16'(player_y), 16'd1);
    chk("rst_keys", 16'(key_num), 16'd0);
    chk("rst_health", 16'(health), 16'd100);
    chk("rst_ready", 16'(move_ready), 16'd1);
    chk("rst_rd_en", 16'(map_rd_en), 16'd0);
    chk("rst_wr_en", 16'(map_wr_en), 16'd0);
    chk("rst_done", 16'(move_done), 16'd0);
    chk("rst_blocked", 16'(move_blocked), 16'd0);
    chk("rst_rd_addr", 16'(map_rd_addr), 16'd0);
    chk("rst_wr_addr", 16'(map_wr_addr), 16'd0);
    chk("rst_wr_data", map_wr_data, 16'd0);
    chk("rst_state", 16'(state_dbg), 16'(S_IDLE));

    // Ground, key, door, door without key, wall
    do_move("ground", DIR_RIGHT, 1, 0, 0, 8'h12, 4'd2, 4'd1, 4'd0, 8'd100);
    do_move("key",    DIR_RIGHT, 1, 0, 1, 8'h13, 4'd3, 4'd1, 4'd1, 8'd100);
    do_move("door",   DIR_RIGHT, 1, 0, 1, 8'h14, 4'd4, 4'd1, 4'd0, 8'd100);
    do_move("door_nokey", DIR_RIGHT, 1, 1, 0, 8'h15, 4'd4, 4'd1, 4'd0, 8'd100);
    chk("door_kept", mem[8'h15], RS_door_0);
    do_move("wall",   DIR_DOWN,  1, 1, 0, 8'h24, 4'd4, 4'd1, 4'd0, 8'd100);

    // Slimes: 32 kills take health from 100 down to 4
    pk = 4'd0;
    ph = 8'd100;
    for (int k = 0; k < 32; k++) begin
      ph = ph - 8'd3;
      if (k % 2 == 0) begin
        mem[8'h15] = RS_slime_0;
        do_move("slime_run", DIR_RIGHT, 1, 0, 1, 8'h15, 4'd5, 4'd1, pk, ph);
      end else begin
        mem[8'h14] = RS_slime_1;
        do_move("slime_run", DIR_LEFT, 1, 0, 1, 8'h14, 4'd4, 4'd1, pk, ph);
      end
    end
    chk("health_at_4", 16'(health), 16'd4);
    mem[8'h15] = RS_slime_0;
    do_move("slime_h4", DIR_RIGHT, 1, 0, 1, 8'h15, 4'd5, 4'd1, 4'd0, 8'd1);
    chk("slime_consumed", mem[8'h15], RS_ground_0);
    mem[8'h14] = RS_slime_0;
    do_move("slime_h1", DIR_LEFT, 1, 1, 0, 8'h14, 4'd5, 4'd1, 4'd0, 8'd1);
    chk("slime_kept", mem[8'h14], RS_slime_0);

    // Keys saturate at 15 but are still consumed
    for (int k = 0; k < 16; k++) begin
      pk = (k < 15) ? 4'(k + 1) : 4'd15;
      if (k % 2 == 0) begin
        mem[8'h16] = RS_key_0;
        do_move("key_run", DIR_RIGHT, 1, 0, 1, 8'h16, 4'd6, 4'd1, pk, 8'd1);
      end else begin
        mem[8'h15] = RS_key_0;
        do_move("key_run", DIR_LEFT, 1, 0, 1, 8'h15, 4'd5, 4'd1, pk, 8'd1);
      end
    end
    chk("keys_sat", 16'(key_num), 16'd15);

    // Reset during EVAL discards the move
    mem[8'h16] = RS_key_0;
    move_valid = 1'b1;
    move_dir   = DIR_RIGHT;
    cyc();
    move_valid = 1'b0;
    cyc();
    chk("mid_state_eval", 16'(state_dbg), 16'(S_EVAL));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 16'(player_x), 16'd1);
    chk("mid_rst_y", 16'(player_y), 16'd1);
    chk("mid_rst_keys", 16'(key_num), 16'd0);
    chk("mid_rst_health", 16'(health), 16'd100);
    chk("mid_rst_ready", 16'(move_ready), 16'd1);
    chk("mid_rst_rd_addr", 16'(map_rd_addr), 16'd0);
    chk("mid_rst_wr_en", 16'(map_wr_en), 16'd0);
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_wr_en", 16'(map_wr_en), 16'd0);
      chk("post_rst_done", 16'(move_done), 16'd0);
      chk("post_rst_x", 16'(player_x), 16'd1);
    end
    chk("key_not_taken", mem[8'h16], RS_key_0);

    // Grid edges on all four sides
    do_move("to_x0", DIR_LEFT, 1, 0, 0, 8'h10, 4'd0, 4'd1, 4'd0, 8'd100);
    do_move("edge_left", DIR_LEFT, 0, 1, 0, 8'h00, 4'd0, 4'd1, 4'd0, 8'd100);
    do_move("to_y0", DIR_UP, 1, 0, 0, 8'h00, 4'd0, 4'd0, 4'd0, 8'd100);
    do_move("edge_up", DIR_UP, 0, 1, 0, 8'h00, 4'd0, 4'd0, 4'd0, 8'd100);
    px = 4'd0;
    for (int i = 0; i < 15; i++) begin
      px = px + 4'd1;
      do_move("run_right", DIR_RIGHT, 1, 0, 0, {4'd0, px}, px, 4'd0, 4'd0, 8'd100);
    end
    do_move("edge_right", DIR_RIGHT, 0, 1, 0, 8'h00, 4'd15, 4'd0, 4'd0, 8'd100);
    py = 4'd0;
    for (int i = 0; i < 15; i++) begin
      py = py + 4'd1;
      do_move("run_down", DIR_DOWN, 1, 0, 0, {py, 4'hF}, 4'd15, py, 4'd0, 8'd100);
    end
    do_move("edge_down", DIR_DOWN, 0, 1, 0, 8'h00, 4'd15, 4'd15, 4'd0, 8'd100);

    // move_valid held high: one move every 4 cycles
    chk("b2b_ready0", 16'(move_ready), 16'd1);
    done_cnt    = 0;
    ready_cnt   = 0;
    first_ready = 0;
    move_valid  = 1'b1;
    move_dir    = DIR_LEFT;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (move_done) done_cnt++;
      if (move_ready) begin
        ready_cnt++;
        if (first_ready == 0) first_ready = i;
      end
    end
    move_valid = 1'b0;
    chk("b2b_done_cnt", 16'(done_cnt), 16'd3);
    chk("b2b_ready_cnt", 16'(ready_cnt), 16'd3);
    chk("b2b_first_ready", 16'(first_ready), 16'd4);
    repeat (6) cyc();
    chk("b2b_x", 16'(player_x), 16'd12);
    chk("b2b_y", 16'(player_y), 16'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
